// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined floating-point multiplier with
// valid/ready flow control, selectable rounding (nearest-even or truncate),
// special-value handling and per-result exception flags.
// Subnormal operands are treated as zero and tiny results flush to zero.
// Stages: S1 unpack/classify/exponent sum, S2 significand multiply,
// S3 normalise/round/pack into the output register.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic [3:0]           out_flags
);

    localparam int EW = EXP_W + 2;       // signed working exponent width
    localparam int SW = MAN_W + 1;       // significand width incl. hidden bit
    localparam int PW = 2 * MAN_W + 2;   // full product width

    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXN  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0]     QNAN_FRAC = {1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic out_valid_q, out_valid_d;
    logic adv1, adv2;

    // Handshake: a stage may load when the stage ahead is empty or moving on.
    always_comb begin
        adv2        = ~out_valid_q | out_ready;
        adv1        = ~v2_q | adv2;
        in_ready    = ~v1_q | adv1;
        v1_d        = in_ready ? in_valid : v1_q;
        v2_d        = adv1 ? v1_q : v2_q;
        out_valid_d = adv2 ? v2_q : out_valid_q;
    end

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, exponent sum
    // ------------------------------------------------------------------
    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    logic                 sign1_q, sign1_d;
    logic                 nan1_q, nan1_d;
    logic                 inf1_q, inf1_d;
    logic                 zero1_q, zero1_d;
    logic                 rnd1_q, rnd1_d;
    logic signed [EW-1:0] exp1_q, exp1_d;
    logic [SW-1:0]        ma1_q, ma1_d;
    logic [SW-1:0]        mb1_q, mb1_d;

    // S1 next-state: decode both operands when a new pair is accepted.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        {sa, ea, fa} = in_a;
        {sb, eb, fb} = in_b;
        a_zero = (ea == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_zero = (eb == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);

        sign1_d = sign1_q;
        nan1_d  = nan1_q;
        inf1_d  = inf1_q;
        zero1_d = zero1_q;
        rnd1_d  = rnd1_q;
        exp1_d  = exp1_q;
        ma1_d   = ma1_q;
        mb1_d   = mb1_q;
        if (in_valid && in_ready) begin
            sign1_d = sa ^ sb;
            nan1_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            inf1_d  = a_inf | b_inf;
            zero1_d = a_zero | b_zero;
            rnd1_d  = in_rnd;
            exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            ma1_d   = {1'b1, fa};
            mb1_d   = {1'b1, fb};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand multiply
    // ------------------------------------------------------------------
    logic                 sign2_q, sign2_d;
    logic                 nan2_q, nan2_d;
    logic                 inf2_q, inf2_d;
    logic                 zero2_q, zero2_d;
    logic                 rnd2_q, rnd2_d;
    logic signed [EW-1:0] exp2_q, exp2_d;
    logic [PW-1:0]        prod2_q, prod2_d;

    // S2 next-state: full-width product, side-band fields carried along.
    always_comb begin
        sign2_d = sign2_q;
        nan2_d  = nan2_q;
        inf2_d  = inf2_q;
        zero2_d = zero2_q;
        rnd2_d  = rnd2_q;
        exp2_d  = exp2_q;
        prod2_d = prod2_q;
        if (adv1 && v1_q) begin
            sign2_d = sign1_q;
            nan2_d  = nan1_q;
            inf2_d  = inf1_q;
            zero2_d = zero1_q;
            rnd2_d  = rnd1_q;
            exp2_d  = exp1_q;
            prod2_d = PW'(ma1_q) * PW'(mb1_q);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, special cases, pack
    // ------------------------------------------------------------------
    logic [PW-1:0]        norm;
    logic [SW-1:0]        mant;
    logic                 guard, sticky, inc, carry;
    logic [MAN_W-1:0]     frac_r;
    logic signed [EW-1:0] exp_r;
    logic [EXP_W+MAN_W:0] res_data;
    logic [3:0]           res_flags;
    logic [EXP_W+MAN_W:0] out_data_q, out_data_d;
    logic [3:0]           out_flags_q, out_flags_d;

    // S3 next-state: round the product and pick the result by priority.
    always_comb begin
        // Product lies in [1,4); bring it to [1,2) keeping the hidden bit on top.
        norm   = prod2_q[PW-1] ? prod2_q : (prod2_q << 1);
        exp_r  = exp2_q + EW'(prod2_q[PW-1]);
        mant   = norm[PW-1 -: SW];
        guard  = norm[PW-1-SW];
        sticky = |norm[PW-2-SW:0];
        inc    = ~rnd2_q & guard & (sticky | mant[0]);
        // An all-ones significand rounding up wraps the fraction to zero.
        carry  = inc & (&mant);
        frac_r = mant[MAN_W-1:0] + MAN_W'(inc);
        if (carry) begin
            exp_r = exp_r + EW'(1);
        end

        res_flags = {3'b000, guard | sticky};
        res_data  = {sign2_q, exp_r[EXP_W-1:0], frac_r};
        if (nan2_q) begin
            res_data  = {1'b0, EXP_ONES, QNAN_FRAC};
            res_flags = 4'b1000;
        end else if (inf2_q) begin
            res_data  = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
            res_flags = 4'b0000;
        end else if (zero2_q) begin
            res_data  = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
            res_flags = 4'b0000;
        end else if (exp_r >= E_MAX) begin
            res_data  = rnd2_q ? {sign2_q, EXP_MAXN, {MAN_W{1'b1}}}
                               : {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
            res_flags = 4'b0101;
        end else if (exp_r <= E_ZERO) begin
            res_data  = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
            res_flags = 4'b0011;
        end

        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (adv2 && v2_q) begin
            out_data_d  = res_data;
            out_flags_d = res_flags;
        end
    end

    // Control and output registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of block evaluation order.
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    // Datapath stage registers.
    always_ff @(posedge clk) begin
        // NOTE: these carry no reset; they are only ever read behind a stage
        // valid bit, and the valid bits are reset.
        sign1_q <= sign1_d;
        nan1_q  <= nan1_d;
        inf1_q  <= inf1_d;
        zero1_q <= zero1_d;
        rnd1_q  <= rnd1_d;
        exp1_q  <= exp1_d;
        ma1_q   <= ma1_d;
        mb1_q   <= mb1_d;
        sign2_q <= sign2_d;
        nan2_q  <= nan2_d;
        inf2_q  <= inf2_d;
        zero2_q <= zero2_d;
        rnd2_q  <= rnd2_d;
        exp2_q  <= exp2_d;
        prod2_q <= prod2_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: scoreboard bench for fp_mult_pipe (single precision).
// Expected results come from an integer-arithmetic reference model that
// rounds the exact product by comparing the discarded remainder to one half.
module tb_fp_mult_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_rnd    = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   out_flags;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q[$];      // expected {flags, data}, oldest first
    logic        ready_random = 1'b0;
    logic        ready_hold   = 1'b0;

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    // Reference: exact product, then shift into [2^23, 2^24) and round.
    function automatic logic [35:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic rnd);
        logic              s, a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, inexact;
        int                ea, eb, e, sh;
        longint unsigned   ma, mb, p, keep, rem, half;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        a_zero = (ea == 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf)
            return {4'b0000, s, 8'hFF, 23'h0};
        if (a_zero || b_zero)
            return {4'b0000, s, 31'h0};
        ma = 64'h800000 + 64'(a[22:0]);
        mb = 64'h800000 + 64'(b[22:0]);
        p  = ma * mb;
        sh = 0;
        while ((p >> sh) >= 64'd16777216) sh++;
        keep    = p >> sh;
        rem     = p - (keep << sh);
        half    = 64'd1 << (sh - 1);
        e       = ea + eb - 127 + sh - 23;
        inexact = (rem != 0);
        if (!rnd && ((rem > half) || (rem == half && keep[0]))) keep++;
        if (keep == 64'd16777216) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255)
            return rnd ? {4'b0101, s, 8'hFE, 23'h7FFFFF} : {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          c;
        c = int'($urandom_range(0, 15));
        f = 23'($urandom);
        case (c)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f[0] = 1'b1; end
            3, 4:    e = 8'($urandom_range(200, 254));
            5, 6:    e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Present one operand pair and hold it until it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic r);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_rnd   = r;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single operation on an empty, free-running pipeline against a fixed value.
    task automatic expect_result(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic r, input logic [35:0] want);
        int n = 0;
        send(a, b, r);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_valid"}, 36'(out_valid), 36'd1);
        check(name, {out_flags, out_data}, want);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 36'(exp_q.size()), 36'd0);
    endtask

    // Downstream ready: either held or randomly toggled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_random ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    end

    // Scoreboard monitor: sample mid-cycle, compare front, pop on transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_ready", 36'(in_ready), 36'(!(exp_q.size() == 3 && !out_ready)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing outstanding",
                             {out_flags, out_data});
                end else begin
                    check("result", {out_flags, out_data}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_mult(in_a, in_b, in_rnd));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 36'(out_valid), 36'd0);
        check("reset_out_data",  36'(out_data),  36'd0);
        check("reset_out_flags", 36'(out_flags), 36'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_hold = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 36'(in_ready), 36'd1);
        @(posedge clk);
        #1;

        // Latency: 2.0 * 3.0
        in_a = 32'h40000000; in_b = 32'h40400000; in_rnd = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk); check("latency_c1", 36'(out_valid), 36'd0);
        @(negedge clk); check("latency_c2", 36'(out_valid), 36'd0);
        @(negedge clk); check("latency_c3", 36'(out_valid), 36'd1);
        check("mul_2x3", {out_flags, out_data}, {4'b0000, 32'h40C00000});
        @(posedge clk);
        #1;

        // Rounding, carry-out, special values and range boundaries
        expect_result("rne_tie_up",    32'h3F800001, 32'h3FC00000, 1'b0, {4'b0001, 32'h3FC00002});
        expect_result("trunc",         32'h3F800001, 32'h3FC00000, 1'b1, {4'b0001, 32'h3FC00001});
        expect_result("round_carry",   32'h3F918E00, 32'h3FE12000, 1'b0, {4'b0001, 32'h40000000});
        expect_result("trunc_nocarry", 32'h3F918E00, 32'h3FE12000, 1'b1, {4'b0001, 32'h3FFFFFFF});
        expect_result("ovf_rne",       32'h7F000000, 32'h7F000000, 1'b0, {4'b0101, 32'h7F800000});
        expect_result("ovf_trunc",     32'h7F000000, 32'h7F000000, 1'b1, {4'b0101, 32'h7F7FFFFF});
        expect_result("ovf_edge",      32'h7F000000, 32'h40000000, 1'b0, {4'b0101, 32'h7F800000});
        expect_result("max_normal",    32'h7F000000, 32'h3F800000, 1'b0, {4'b0000, 32'h7F000000});
        expect_result("udf",           32'h00800000, 32'h3F000000, 1'b0, {4'b0011, 32'h00000000});
        expect_result("min_normal",    32'h00800000, 32'h3F800000, 1'b0, {4'b0000, 32'h00800000});
        expect_result("inf_x_zero",    32'h7F800000, 32'h00000000, 1'b0, {4'b1000, 32'h7FC00000});
        expect_result("neg_inf",       32'hFF800000, 32'h40000000, 1'b0, {4'b0000, 32'hFF800000});
        expect_result("nan_operand",   32'h7FC00001, 32'h3F800000, 1'b0, {4'b1000, 32'h7FC00000});
        expect_result("neg_zero",      32'h80000000, 32'h3F800000, 1'b0, {4'b0000, 32'h80000000});
        expect_result("subnormal",     32'h00000001, 32'h7F000000, 1'b0, {4'b0000, 32'h00000000});

        // Back-to-back random stream with random backpressure
        ready_random = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end
        ready_random = 1'b0;
        ready_hold   = 1'b1;
        drain("drain_random");

        // Mid-flight reset: fill all three stages with downstream stalled
        ready_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send({1'b0, 8'd127, 23'($urandom)}, {1'b1, 8'd128, 23'($urandom)}, 1'b0);
        end
        @(negedge clk);
        check("full_stall_in_ready", 36'(in_ready), 36'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        ready_hold = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_a     = 32'h40400000;
        in_b     = 32'hC0A00000;
        in_rnd   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 36'(out_valid), 36'd0);
        check("post_reset_in_ready",  36'(in_ready),  36'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk); check("post_reset_c1", 36'(out_valid), 36'd0);
        @(negedge clk); check("post_reset_c2", 36'(out_valid), 36'd0);
        @(negedge clk); check("post_reset_c3", 36'(out_valid), 36'd1);
        check("post_reset_value", {out_flags, out_data}, {4'b0000, 32'hC1700000});
        repeat (10) @(posedge clk);
        #1;
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
